// File: rtl/segment_static_decoder.sv
// Static single-digit hex 7-segment driver with a registered segment bus,
// optional common-anode inversion and optional parameter-driven blinking.
module segment_static_decoder #(
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DP_ON          = 1'b0,
  parameter int unsigned BLINK_DIV      = 0,
  parameter int          CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  output logic [7:0] segment
);

  localparam logic [7:0] POL_MASK = {8{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0] r_cnt;
  logic             r_visible;
  logic [7:0]       r_segment;
  logic [6:0]       w_glyph;
  logic [7:0]       w_seg_next;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  always_comb begin
    w_glyph = 7'h00;
    case (data)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  // The phase in effect before the edge decides this edge's output, so the
  // wrap edge still shows a glyph and each phase lasts exactly BLINK_DIV cycles.
  always_comb begin
    w_seg_next = 8'h00;
    if (r_visible) begin
      w_seg_next = {DP_ON, w_glyph};
    end
    w_seg_next = w_seg_next ^ POL_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_visible <= 1'b1;
      r_segment <= POL_MASK;
    end else begin
      r_segment <= w_seg_next;
      if (BLINK_DIV != 0) begin
        if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
          r_cnt     <= '0;
          r_visible <= ~r_visible;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt     <= '0;
        r_visible <= 1'b1;
      end
    end
  end

  assign segment = r_segment;

endmodule

// File: tb/tb_segment_static_decoder.sv
// Randomized self-checking bench: three parameterizations driven in lockstep
// and compared against a cycle-count based reference model.
module tb_segment_static_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data = 4'h0;
  logic [7:0] seg_def, seg_al, seg_blk;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [16];
  int         run_len = 0;

  always #5 clk = ~clk;

  segment_static_decoder u_def (
    .clk(clk), .rst_n(rst_n), .data(data), .segment(seg_def)
  );

  segment_static_decoder #(.SEG_ACTIVE_LOW(1'b1), .DP_ON(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .data(data), .segment(seg_al)
  );

  segment_static_decoder #(.BLINK_DIV(4), .CNT_W(8)) u_blk (
    .clk(clk), .rst_n(rst_n), .data(data), .segment(seg_blk)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs, take one edge, then compare all three instances to the model.
  // Model: run_len counts non-reset edges since the last reset edge; edge n is
  // visible when (n-1)/4 is even.
  task automatic step(input logic rst_v, input logic [3:0] d);
    logic [7:0] e_def, e_al, e_blk;
    bit vis;
    rst_n = rst_v;
    data  = d;
    @(posedge clk);
    if (!rst_v) begin
      run_len = 0;
      e_def = 8'h00;
      e_al  = 8'hFF;
      e_blk = 8'h00;
    end else begin
      run_len++;
      vis   = (((run_len - 1) / 4) % 2) == 0;
      e_def = {1'b0, glyph_tab[d]};
      e_al  = ~{1'b1, glyph_tab[d]};
      e_blk = vis ? {1'b0, glyph_tab[d]} : 8'h00;
    end
    #1;
    $display("edge rst_n=%0d data=%h def=%h al=%h blk=%h", rst_v, d, seg_def, seg_al, seg_blk);
    check("default", seg_def, e_def);
    check("active_low", seg_al, e_al);
    check("blink4", seg_blk, e_blk);
    @(negedge clk);
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    @(negedge clk);

    // reset held two cycles, then full hex sweep
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i));

    // hold 8 across several blink phases
    step(1'b0, 4'h8);
    for (int i = 0; i < 16; i++) step(1'b1, 4'h8);

    // reset in the middle of a visible phase
    step(1'b1, 4'h8);
    step(1'b0, 4'h8);
    for (int i = 0; i < 6; i++) step(1'b1, 4'h8);

    // data change 1 -> 2 while blanked
    step(1'b0, 4'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h1);
    for (int i = 0; i < 7; i++) step(1'b1, 4'h2);

    // random data with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) != 0), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment_static_decoder.md
Name: segment_static_decoder

Overview:
Static single-digit 7-segment driver. It samples a 4-bit hex value every clock and drives one 8-bit segment bus (7 segments plus decimal point) with the hex glyph 0-F. It sits between the user/control logic and the board's single 7-segment digit. The anode/cathode common line is tied statically outside the block, so there is no scanning. Optional polarity inversion and optional blink are set by parameters only, so the instance needs only clk, rst_n, data and segment.

Parameters:
SEG_ACTIVE_LOW, 0, 0 = segment lit when bit is 1 (common cathode); 1 = all 8 output bits inverted (common anode).
DP_ON, 0, 1 = decimal point lit whenever the display is not blanked; 0 = decimal point always off.
BLINK_DIV, 0, 0 = no blinking; N>0 = display toggles between glyph and blank every N clock cycles.
CNT_W, 32, width of the blink counter; BLINK_DIV must be < 2^CNT_W.

Ports:
clk  input  1  system clock, all state rising-edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
data  input  4  hex digit to display, 0x0-0xF.
segment  output  8  {dp,g,f,e,d,c,b,a}; registered output.

Behaviour:
- Single clock domain. Reset is synchronous, active-low. While rst_n=0 at a clock edge, all state clears.
- Reset state:
  - segment = blank: 8'h00 if SEG_ACTIVE_LOW=0, 8'hFF if SEG_ACTIVE_LOW=1.
  - Blink counter = 0.
  - Blink phase = visible.
- Latency: segment reflects the data sampled at edge k starting at edge k. It is one register stage: segment at edge k+1 shows data held before edge k+1. There is no combinational path from data to segment.
- Active-high glyphs (bits g..a), with dp added per DP_ON:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Decimal point: bit7 = DP_ON when visible, 0 when blanked (before any polarity inversion).
- Polarity: with SEG_ACTIVE_LOW=1, the final 8-bit value is bitwise inverted, including dp.
- Blink with BLINK_DIV=0: the counter is held at 0 and the display is always visible.
- Blink with BLINK_DIV>0:
  - Counter increments every cycle after reset.
  - When counter == BLINK_DIV-1, it wraps to 0 and the blink phase toggles.
  - During the blank phase, segment = blank code.
  - data continues to be sampled during the blank phase; the next visible phase shows the latest value.
- data change during the blank phase has no visible effect until the phase returns to visible. The counter is not reset by a data change.
- Reset asserted mid-blink: the next edge forces blank output, counter 0 and phase visible. The first visible glyph appears on the first edge after rst_n returns to 1.
- X or Z on data is not required to be handled; the data input is always driven.

Test Plan:
- Defaults, reset low for 2 cycles -> segment=8'h00. Release reset, then apply data=0,1,2,3 each for 10 ns steps -> segment=8'h3F, 8'h06, 8'h5B, 8'h4F, each one clock after the data change.
- Defaults, sweep data 0x4..0xF -> segment=66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 in order.
- SEG_ACTIVE_LOW=1, DP_ON=1, data=0 -> segment=8'h40. Reset -> segment=8'hFF.
- BLINK_DIV=4, data=8 held -> segment alternates 4 cycles 8'h7F and 4 cycles 8'h00, repeating.
- BLINK_DIV=4, assert rst_n=0 for one edge mid-visible-phase -> segment=8'h00 on that edge. After release, 4 visible cycles of the current glyph follow.
- Change data from 1 to 2 during the blank phase -> the next visible phase shows 8'h5B immediately; blink period is unchanged.
